regfile_scoreboard: RTL

- Parametrised successor to the pipeline's integer register file, used in the decode stage.
- Holds NREGS registers of XLEN bits, with NREAD combinational read ports and one synchronous write port.
- Adds optional write-to-read bypass, a hardwired zero register, asynchronous clear, and a per-register pending-write scoreboard.
- Decode uses the scoreboard's stall output to hold back an instruction whose source operand has an unretired producer.

---
 rtl/regfile_scoreboard.sv | 86 ++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Decode-stage integer register file with write bypass, optional zero register
// and a per-register pending-write scoreboard that drives operand stalls.
module regfile_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   A,
  input  logic [NREAD-1:0]      RE,
  output logic [NREAD*XLEN-1:0] RD,
  input  logic                  WE3,
  input  logic [AW-1:0]         A3,
  input  logic [XLEN-1:0]       WD3,
  input  logic                  ISSUE,
  input  logic [AW-1:0]         ISSUE_RD,
  input  logic                  FLUSH,
  output logic [NREAD-1:0]      BUSY,
  output logic                  STALL
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);
  localparam bit HAS_BYP  = (BYPASS != 0);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;
  logic             wr_ok;
  logic             issue_ok;

  // Writes and issues that target the hardwired zero register have no effect.
  assign wr_ok    = WE3   && !(HAS_ZERO && (A3 == '0));
  assign issue_ok = ISSUE && !(HAS_ZERO && (ISSUE_RD == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[A3] <= WD3;
    end
  end

  // Issue is applied after the retire-clear so a new producer keeps ownership.
  always_comb begin
    pend_d = pend_q;
    if (FLUSH) begin
      pend_d = '0;
    end else begin
      if (WE3)      pend_d[A3]       = 1'b0;
      if (issue_ok) pend_d[ISSUE_RD] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  for (genvar p = 0; p < int'(NREAD); p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit;
    logic            is_zero;
    logic [XLEN-1:0] data;

    assign addr    = A[p*AW +: AW];
    assign hit     = HAS_BYP && wr_ok && (A3 == addr);
    assign is_zero = HAS_ZERO && (addr == '0);

    // Reset and the zero register override any bypassed write data.
    always_comb begin
      data = regs_q[addr];
      if (hit)           data = WD3;
      if (is_zero || rst) data = '0;
    end

    assign RD[p*XLEN +: XLEN] = data;
    assign BUSY[p] = RE[p] && pend_q[addr] && !hit && !is_zero && !rst;
  end

  assign STALL = |BUSY;

endmodule
